memory_shared: RTL and testbench
================================

# memory_shared

Parametrised single-array memory shared by the processor's instruction-fetch and load/store paths. It replaces separate fixed-size instruction and data memories with one array behind two request/acknowledge ports. A round-robin arbiter and a configurable wait-state counter sit in front of the array. The processor can therefore fetch code that it wrote through the data port, and the memory's latency can be stretched to model slower storage.

## Interface
- DATA_W, default 16: word width in bits.
- ADDR_W, default 6: address width of both ports.
- DEPTH, default 64: number of implemented words. Must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W.
- WAIT_STATES, default 0: extra cycles inserted before each array access. Legal range 0..7.

Ports:
- Clock  in  1  sole clock; all state changes on its rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-read request; held until i_ack.
- i_addr  in  ADDR_W  instruction address; stable while i_req is high.
- i_ack  out  1  one-cycle pulse: instruction read complete.
- i_q  out  DATA_W  instruction word; updated only at the i_ack pulse.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  ADDR_W  data address; stable while d_req is high.
- d_data  in  DATA_W  write data; stable while d_req is high.
- d_ack  out  1  one-cycle pulse: data access complete.
- d_q  out  DATA_W  data read word; updated only at a data-read d_ack.
- err  out  1  pulses together with i_ack or d_ack when that access's address ≥ DEPTH.

## Operation
FSM states: IDLE, ACCESS, RESP.

IDLE:
- On an edge with any request high, the arbiter selects one port.
- The block latches that port's address, and for the data port also we and data.
- It loads wcnt = WAIT_STATES and goes to ACCESS.

Arbitration:
- A single request wins.
- If both requests are high, the grant goes to the port not granted last (last_grant register).
- last_grant updates on every grant.

ACCESS:
- While wcnt ≠ 0, each edge decrements wcnt.
- On the edge where wcnt = 0, the array access occurs, the block registers ack for the granted port, and the state goes to RESP.

Array access:
- Read, address < DEPTH: q ← Mem[addr].
- Write, address < DEPTH: Mem[addr] ← d_data. d_q holds its old value.
- Address ≥ DEPTH: a read returns 0, a write is dropped, err = 1 for the ack cycle. The ack is still given.

RESP:
- The ack is high for exactly this one cycle.
- Next edge: ack drops and the state goes to IDLE.
- The requester must deassert req during the ack cycle. A req still high in IDLE is a new request.

Other rules:
- The non-granted port's request stays pending, untouched, and is arbitrated in the next IDLE.
- Memory contents are not initialised and are not cleared by reset. A bench writes before it reads.
- A data write followed by an instruction read of the same address returns the written word (self-modifying code).

## Timing
- Resetn low: asynchronously forces the following, regardless of state:
  - state = IDLE, wcnt = 0
  - i_ack = d_ack = err = 0
  - i_q = d_q = 0
  - last_grant = instruction, so data wins the first tie.
- An access in flight when reset hits is abandoned. No ack is issued. Whether an interrupted write landed is not guaranteed; all other words are preserved.
- Latency:
  - req sampled high in IDLE at edge k gives ack high after edge k+WAIT_STATES+1.
  - With WAIT_STATES = 0, ack follows one cycle after the grant edge.
- Throughput: one access per WAIT_STATES+3 cycles with back-to-back requests. Under two saturating ports, grants strictly alternate.
- i_q, d_q and err are valid in the ack cycle. i_q and d_q then hold until the next read of their own port or reset. err is 0 outside ack cycles.
- Requests are only sampled in IDLE, so simultaneous arrival during ACCESS/RESP has no effect until the return to IDLE.

## Test plan
1. Write then read back, WAIT_STATES=0:
   - Reset, then data write 0x1234 to addr 3: d_ack after 1 cycle, d_q stays 0.
   - Data read addr 3: d_ack with d_q = 0x1234, err = 0.
2. Tie after reset, WAIT_STATES=0:
   - Raise i_req (addr 3) and d_req (read addr 3) on the same edge: data acked first, instruction 3 cycles later with i_q = 0x1234.
   - Hold both ports requesting: grants alternate D, I, D, I.
3. Self-modify:
   - Data write 0xF000 to addr 5, then instruction read addr 5: i_q = 0xF000.
   - d_q unchanged by the instruction read.
4. Out of range, DEPTH=40, ADDR_W=6:
   - Data write 0xAAAA to addr 50: ack with err = 1.
   - Read addr 50: d_q = 0, err = 1.
   - Write/read addr 39 with 0x5555: value returned, err = 0.
5. Wait states and reset abort, WAIT_STATES=3:
   - Data read: d_ack exactly 4 cycles after the grant edge.
   - Repeat, pulsing Resetn low 2 cycles after the grant: no ack, i_q = d_q = 0.
   - Prior contents at addr 3 are still read back correctly after reset.

Source files
------------

// File: rtl/memory_shared.sv
// Single memory array shared by instruction-fetch and load/store ports.
// Round-robin arbitration, programmable wait states, registered ack/err/q outputs.
module memory_shared #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_q,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_q,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [2:0]      WS_C    = 3'(WAIT_STATES);

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state,  w_state_nxt;
  logic [2:0]        r_wcnt,   w_wcnt_nxt;
  logic              r_gnt_d,  w_gnt_d_nxt;
  logic              r_last_d, w_last_d_nxt;
  logic              r_we,     w_we_nxt;
  logic [ADDR_W-1:0] r_addr,   w_addr_nxt;
  logic [DATA_W-1:0] r_data,   w_data_nxt;
  logic              r_i_ack,  w_i_ack_nxt;
  logic              r_d_ack,  w_d_ack_nxt;
  logic              r_err,    w_err_nxt;
  logic [DATA_W-1:0] r_i_q,    w_i_q_nxt;
  logic [DATA_W-1:0] r_d_q,    w_d_q_nxt;

  logic              w_in_range;
  logic              w_access;
  logic [DATA_W-1:0] w_rd_word;

  assign w_in_range = ({1'b0, r_addr} < DEPTH_C);
  assign w_access   = (r_state == ACCESS) && (r_wcnt == 3'd0);
  assign w_rd_word  = w_in_range ? r_mem[r_addr] : '0;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state  <= IDLE;
      r_wcnt   <= 3'd0;
      r_gnt_d  <= 1'b0;
      r_last_d <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_i_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      r_err    <= 1'b0;
      r_i_q    <= '0;
      r_d_q    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_gnt_d  <= w_gnt_d_nxt;
      r_last_d <= w_last_d_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_i_ack  <= w_i_ack_nxt;
      r_d_ack  <= w_d_ack_nxt;
      r_err    <= w_err_nxt;
      r_i_q    <= w_i_q_nxt;
      r_d_q    <= w_d_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wcnt_nxt   = r_wcnt;
    w_gnt_d_nxt  = r_gnt_d;
    w_last_d_nxt = r_last_d;
    w_we_nxt     = r_we;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_i_ack_nxt  = 1'b0;
    w_d_ack_nxt  = 1'b0;
    w_err_nxt    = 1'b0;
    w_i_q_nxt    = r_i_q;
    w_d_q_nxt    = r_d_q;
    case (r_state)
      IDLE: begin
        if (i_req || d_req) begin
          // On a tie the port that did not win last time gets the grant
          w_gnt_d_nxt  = d_req && (!i_req || !r_last_d);
          w_last_d_nxt = w_gnt_d_nxt;
          w_addr_nxt   = w_gnt_d_nxt ? d_addr : i_addr;
          w_we_nxt     = w_gnt_d_nxt && d_we;
          w_data_nxt   = d_data;
          w_wcnt_nxt   = WS_C;
          w_state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        if (r_wcnt != 3'd0) begin
          w_wcnt_nxt = r_wcnt - 3'd1;
        end else begin
          w_state_nxt = RESP;
          w_err_nxt   = !w_in_range;
          if (r_gnt_d) begin
            w_d_ack_nxt = 1'b1;
            if (!r_we) w_d_q_nxt = w_rd_word;
          end else begin
            w_i_ack_nxt = 1'b1;
            w_i_q_nxt   = w_rd_word;
          end
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Array is deliberately not reset; an aborted access never reaches ACCESS with wcnt=0
  always_ff @(posedge Clock) begin
    if (w_access && r_we && w_in_range) r_mem[r_addr] <= r_data;
  end

  assign i_ack = r_i_ack;
  assign d_ack = r_d_ack;
  assign err   = r_err;
  assign i_q   = r_i_q;
  assign d_q   = r_d_q;

endmodule

// File: tb/tb_memory_shared.sv
// Self-checking bench for memory_shared: two instances (DEPTH 40 / no wait states,
// DEPTH 64 / three wait states) compared against a word-level memory model.
module tb_memory_shared;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int DEP0 = 40;
  localparam int WS0  = 0;
  localparam int DEP1 = 64;
  localparam int WS1  = 3;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic          rstn   [2];
  logic          i_req  [2];
  logic [AW-1:0] i_addr [2];
  logic          i_ack  [2];
  logic [DW-1:0] i_q    [2];
  logic          d_req  [2];
  logic          d_we   [2];
  logic [AW-1:0] d_addr [2];
  logic [DW-1:0] d_data [2];
  logic          d_ack  [2];
  logic [DW-1:0] d_q    [2];
  logic          err    [2];

  memory_shared #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP0), .WAIT_STATES(WS0)) u_dut0 (
    .Clock(Clock), .Resetn(rstn[0]),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ack(i_ack[0]), .i_q(i_q[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_data(d_data[0]),
    .d_ack(d_ack[0]), .d_q(d_q[0]), .err(err[0]));

  memory_shared #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP1), .WAIT_STATES(WS1)) u_dut1 (
    .Clock(Clock), .Resetn(rstn[1]),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ack(i_ack[1]), .i_q(i_q[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_data(d_data[1]),
    .d_ack(d_ack[1]), .d_q(d_q[1]), .err(err[1]));

  int checks = 0;
  int errors = 0;

  // Reference model: word store per instance plus each port's last returned word
  logic [DW-1:0] m_mem [2][64];
  bit            m_val [2][64];
  logic [DW-1:0] m_iq  [2];
  logic [DW-1:0] m_dq  [2];

  function automatic int depth_of(input int n);
    return (n == 0) ? DEP0 : DEP1;
  endfunction

  function automatic int ws_of(input int n);
    return (n == 0) ? WS0 : WS1;
  endfunction

  function automatic logic [DW-1:0] model_access(input int n, input bit isd, input bit we,
                                                  input int a, input logic [DW-1:0] wd);
    logic [DW-1:0] rd;
    rd = (a < depth_of(n)) ? m_mem[n][a] : '0;
    if (isd && we) begin
      if (a < depth_of(n)) begin
        m_mem[n][a] = wd;
        m_val[n][a] = 1'b1;
      end
      return m_dq[n];
    end
    if (isd) m_dq[n] = rd;
    else     m_iq[n] = rd;
    return rd;
  endfunction

  task automatic apply_reset(input int n);
    rstn[n]  = 1'b0;
    i_req[n] = 1'b0;
    d_req[n] = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    rstn[n] = 1'b1;
    m_iq[n] = '0;
    m_dq[n] = '0;
  endtask

  // Presents one request and waits for its ack; lat counts edges after the grant edge
  task automatic do_access(input int n, input bit isd, input bit we, input int a,
                           input logic [DW-1:0] wd, output int lat,
                           output logic [DW-1:0] q, output logic e, output bit other_ack);
    if (isd) begin
      d_req[n] = 1'b1; d_we[n] = we; d_addr[n] = AW'(a); d_data[n] = wd;
    end else begin
      i_req[n] = 1'b1; i_addr[n] = AW'(a);
    end
    lat = -1;
    other_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge Clock);
      #1;
      if (isd ? i_ack[n] : d_ack[n]) other_ack = 1'b1;
      if (isd ? d_ack[n] : i_ack[n]) begin
        lat = c;
        break;
      end
    end
    q = isd ? d_q[n] : i_q[n];
    e = err[n];
    i_req[n] = 1'b0;
    d_req[n] = 1'b0;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    apply_reset(0);
    apply_reset(1);
    for (int n = 0; n < 2; n++) begin
      checks++; if (i_ack[n] !== 1'b0) begin errors++; $display("FAIL reset_i_ack[%0d]: got %b expected 0", n, i_ack[n]); end
      checks++; if (d_ack[n] !== 1'b0) begin errors++; $display("FAIL reset_d_ack[%0d]: got %b expected 0", n, d_ack[n]); end
      checks++; if (err[n] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b expected 0", n, err[n]); end
      checks++; if (i_q[n] !== '0) begin errors++; $display("FAIL reset_i_q[%0d]: got %h expected 0", n, i_q[n]); end
      checks++; if (d_q[n] !== '0) begin errors++; $display("FAIL reset_d_q[%0d]: got %h expected 0", n, d_q[n]); end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [DW-1:0] q, exp_q; logic e; bit oa;
    exp_q = model_access(0, 1, 1, 3, 16'h1234);
    do_access(0, 1, 1, 3, 16'h1234, lat, q, e, oa);
    checks++; if (lat !== WS0 + 1) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, WS0 + 1); end
    checks++; if (q !== 16'h0000 || q !== exp_q) begin errors++; $display("FAIL wr_d_q_hold: got %h expected 0000", q); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", e); end
    exp_q = model_access(0, 1, 0, 3, '0);
    do_access(0, 1, 0, 3, '0, lat, q, e, oa);
    checks++; if (lat !== WS0 + 1) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, WS0 + 1); end
    checks++; if (q !== 16'h1234 || q !== exp_q) begin errors++; $display("FAIL rd_d_q: got %h expected 1234", q); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", e); end
  endtask

  // Both ports saturate; grants alternate starting with data after reset
  task automatic test_tie();
    int last_c, nack;
    bit exp_d;
    logic [DW-1:0] exp_q;
    apply_reset(0);
    last_c = -1; nack = 0; exp_d = 1'b1;
    i_req[0] = 1'b1; i_addr[0] = 6'd3;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 6'd3; d_data[0] = '0;
    for (int c = 0; c < 60 && nack < 6; c++) begin
      @(posedge Clock);
      #1;
      checks++; if (d_ack[0] && i_ack[0]) begin errors++; $display("FAIL tie_dual_ack: got both acks at cycle %0d expected one", c); end
      if (d_ack[0] || i_ack[0]) begin
        checks++; if (d_ack[0] !== exp_d) begin errors++; $display("FAIL tie_order[%0d]: got data=%b expected data=%b", nack, d_ack[0], exp_d); end
        checks++;
        if (nack == 0 ? (c != 1) : (c - last_c != WS0 + 3)) begin
          errors++; $display("FAIL tie_spacing[%0d]: got cycle %0d after %0d expected gap %0d", nack, c, last_c, WS0 + 3);
        end
        if (d_ack[0]) begin
          exp_q = model_access(0, 1, 0, 3, '0);
          checks++; if (d_q[0] !== exp_q) begin errors++; $display("FAIL tie_d_q: got %h expected %h", d_q[0], exp_q); end
        end else begin
          exp_q = model_access(0, 0, 0, 3, '0);
          checks++; if (i_q[0] !== exp_q) begin errors++; $display("FAIL tie_i_q: got %h expected %h", i_q[0], exp_q); end
        end
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL tie_err: got %b expected 0", err[0]); end
        exp_d = !exp_d;
        last_c = c;
        nack++;
      end
      d_req[0] = !d_ack[0];
      i_req[0] = !i_ack[0];
    end
    checks++; if (nack != 6) begin errors++; $display("FAIL tie_timeout: got %0d acks expected 6", nack); end
    i_req[0] = 1'b0;
    d_req[0] = 1'b0;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_self_modify();
    int lat; logic [DW-1:0] q, exp_q, exp_dq; logic e; bit oa;
    exp_q = model_access(0, 1, 1, 5, 16'hF000);
    do_access(0, 1, 1, 5, 16'hF000, lat, q, e, oa);
    exp_dq = m_dq[0];
    exp_q = model_access(0, 0, 0, 5, '0);
    do_access(0, 0, 0, 5, '0, lat, q, e, oa);
    checks++; if (q !== 16'hF000 || q !== exp_q) begin errors++; $display("FAIL smc_i_q: got %h expected F000", q); end
    checks++; if (lat !== WS0 + 1) begin errors++; $display("FAIL smc_latency: got %0d expected %0d", lat, WS0 + 1); end
    checks++; if (d_q[0] !== exp_dq) begin errors++; $display("FAIL smc_d_q_hold: got %h expected %h", d_q[0], exp_dq); end
    checks++; if (oa !== 1'b0) begin errors++; $display("FAIL smc_stray_ack: got %b expected 0", oa); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [DW-1:0] q, exp_q; logic e; bit oa;
    exp_q = model_access(0, 1, 1, 50, 16'hAAAA);
    do_access(0, 1, 1, 50, 16'hAAAA, lat, q, e, oa);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b expected 1", e); end
    checks++; if (lat !== WS0 + 1) begin errors++; $display("FAIL oor_wr_latency: got %0d expected %0d", lat, WS0 + 1); end
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL oor_err_after: got %b expected 0", err[0]); end
    exp_q = model_access(0, 1, 0, 50, '0);
    do_access(0, 1, 0, 50, '0, lat, q, e, oa);
    checks++; if (q !== 16'h0000 || q !== exp_q) begin errors++; $display("FAIL oor_rd_q: got %h expected 0000", q); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b expected 1", e); end
    exp_q = model_access(0, 1, 1, 39, 16'h5555);
    do_access(0, 1, 1, 39, 16'h5555, lat, q, e, oa);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL edge_wr_err: got %b expected 0", e); end
    exp_q = model_access(0, 1, 0, 39, '0);
    do_access(0, 1, 0, 39, '0, lat, q, e, oa);
    checks++; if (q !== 16'h5555 || q !== exp_q) begin errors++; $display("FAIL edge_rd_q: got %h expected 5555", q); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL edge_rd_err: got %b expected 0", e); end
    exp_q = model_access(0, 0, 0, 63, '0);
    do_access(0, 0, 0, 63, '0, lat, q, e, oa);
    checks++; if (q !== exp_q || e !== 1'b1) begin errors++; $display("FAIL oor_i_rd: got q=%h err=%b expected q=%h err=1", q, e, exp_q); end
  endtask

  task automatic test_wait_abort();
    int lat, acks; logic [DW-1:0] q, exp_q; logic e; bit oa;
    exp_q = model_access(1, 1, 1, 3, 16'hBEEF);
    do_access(1, 1, 1, 3, 16'hBEEF, lat, q, e, oa);
    checks++; if (lat !== WS1 + 1) begin errors++; $display("FAIL ws_wr_latency: got %0d expected %0d", lat, WS1 + 1); end
    exp_q = model_access(1, 1, 0, 3, '0);
    do_access(1, 1, 0, 3, '0, lat, q, e, oa);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ws_rd_latency: got %0d expected 4", lat); end
    checks++; if (q !== 16'hBEEF || q !== exp_q) begin errors++; $display("FAIL ws_rd_q: got %h expected BEEF", q); end
    // Abort a read two cycles after its grant edge
    acks = 0;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 6'd3;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clock);
      #1;
      if (d_ack[1] || i_ack[1]) acks++;
    end
    rstn[1] = 1'b0;
    #1;
    m_iq[1] = '0;
    m_dq[1] = '0;
    checks++; if (d_q[1] !== m_dq[1] || i_q[1] !== m_iq[1]) begin errors++; $display("FAIL abort_q_clear: got i_q=%h d_q=%h expected 0", i_q[1], d_q[1]); end
    d_req[1] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) rstn[1] = 1'b1;
      @(posedge Clock);
      #1;
      if (d_ack[1] || i_ack[1]) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks expected 0", acks); end
    checks++; if (d_q[1] !== '0) begin errors++; $display("FAIL abort_d_q: got %h expected 0", d_q[1]); end
    exp_q = model_access(1, 1, 0, 3, '0);
    do_access(1, 1, 0, 3, '0, lat, q, e, oa);
    checks++; if (q !== 16'hBEEF || q !== exp_q) begin errors++; $display("FAIL abort_keep: got %h expected BEEF", q); end
    checks++; if (lat !== WS1 + 1) begin errors++; $display("FAIL abort_rd_latency: got %0d expected %0d", lat, WS1 + 1); end
  endtask

  task automatic test_random();
    int n, a, lat; bit isd, we, oa; logic [DW-1:0] wd, q, exp_q, exp_other; logic e;
    for (int k = 0; k < 60; k++) begin
      n   = $urandom_range(0, 1);
      isd = 1'($urandom_range(0, 1));
      we  = isd & 1'($urandom_range(0, 1));
      a   = $urandom_range(0, 63);
      wd  = DW'($urandom);
      if (!we && a < depth_of(n) && !m_val[n][a]) begin
        isd = 1'b1;
        we  = 1'b1;
      end
      exp_other = isd ? m_iq[n] : m_dq[n];
      exp_q = model_access(n, isd, we, a, wd);
      do_access(n, isd, we, a, wd, lat, q, e, oa);
      checks++; if (lat !== ws_of(n) + 1) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", k, lat, ws_of(n) + 1); end
      checks++; if (q !== exp_q) begin errors++; $display("FAIL rnd_q[%0d]: got %h expected %h (inst %0d d=%b we=%b a=%0d)", k, q, exp_q, n, isd, we, a); end
      checks++; if (e !== (a >= depth_of(n))) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", k, e, a >= depth_of(n)); end
      checks++;
      if ((isd ? i_q[n] : d_q[n]) !== exp_other) begin
        errors++; $display("FAIL rnd_other_q[%0d]: got %h expected %h", k, isd ? i_q[n] : d_q[n], exp_other);
      end
    end
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      rstn[n] = 1'b0; i_req[n] = 1'b0; i_addr[n] = '0;
      d_req[n] = 1'b0; d_we[n] = 1'b0; d_addr[n] = '0; d_data[n] = '0;
      m_iq[n] = '0; m_dq[n] = '0;
      for (int a = 0; a < 64; a++) begin
        m_mem[n][a] = '0;
        m_val[n][a] = 1'b0;
      end
    end
    @(posedge Clock);
    #1;
    test_reset();
    test_write_read();
    test_tie();
    test_self_modify();
    test_out_of_range();
    test_wait_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
